// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: opcode values,
// FSM state encoding and instruction-register field positions.
package alu_seq_pkg;

  // ALU opcodes carried in IR[31:27]
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_SHR  = 5'b00101;
  localparam logic [4:0] OPC_SHRA = 5'b00110;
  localparam logic [4:0] OPC_SHL  = 5'b00111;
  localparam logic [4:0] OPC_ROR  = 5'b01000;
  localparam logic [4:0] OPC_ROL  = 5'b01001;
  localparam logic [4:0] OPC_AND  = 5'b01010;
  localparam logic [4:0] OPC_OR   = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;

  // Sequencer states
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_T0      = 4'd1;
  localparam logic [3:0] ST_T1      = 4'd2;
  localparam logic [3:0] ST_T2      = 4'd3;
  localparam logic [3:0] ST_DECODE  = 4'd4;
  localparam logic [3:0] ST_T3      = 4'd5;
  localparam logic [3:0] ST_EXEC    = 4'd6;
  localparam logic [3:0] ST_T5      = 4'd7;
  localparam logic [3:0] ST_ILLEGAL = 4'd8;
  localparam logic [3:0] ST_FAULT   = 4'd9;

  // Least-significant bit of each instruction field
  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

endpackage

// File: rtl/alu_opc_classify.sv
// Combinational opcode classifier: sorts an opcode into binary ALU op,
// unary ALU op, or an opcode this ALU does not implement.
module alu_opc_classify
  import alu_seq_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output logic             is_binary,
  output logic             is_unary,
  output logic             is_illegal
);

  // Exactly one class flag is high for any opcode
  always_comb begin
    is_binary  = 1'b0;
    is_unary   = 1'b0;
    is_illegal = 1'b0;
    case (opc)
      OPC_OR, OPC_AND, OPC_ADD, OPC_SUB: is_binary = 1'b1;
      OPC_NOT, OPC_NEG:                  is_unary  = 1'b1;
      OPC_MUL, OPC_DIV, OPC_SHR, OPC_SHRA,
      OPC_SHL, OPC_ROR, OPC_ROL:         is_illegal = 1'b1;
      default:                           is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle control sequencer for a single-bus ALU datapath.
// Fetches an instruction, decodes IR[31:27] and steps Y/Z/register
// transfers for ALU-class opcodes; others produce an illegal_op pulse.
// Optional single-step mode is enabled by defining ALU_SEQ_STEP_EN.
module alu_ctrl_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 5,
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
`ifdef ALU_SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] alu_op,
  output logic              pc_out,
  output logic              pc_in,
  output logic              inc_pc,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              mem_read,
  output logic              ir_in,
  output logic              y_in,
  output logic              z_in,
  output logic              zlo_out,
  output logic              mdr_out,
  output logic [REG_W-1:0]  reg_sel,
  output logic              reg_out,
  output logic              reg_in,
  output logic              illegal_op,
  output logic              mem_fault,
  output logic [15:0]       instr_count
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]             state;
  logic [3:0]             state_nxt;
  logic [CNT_W-1:0]       wait_cnt;
  logic [DATA_W-1:RC_LSB] ir_q;
  logic [OPC_W-1:0]       opc;
  logic                   is_binary;
  logic                   is_unary;
  logic                   is_illegal;
  logic                   start_ok;
  logic                   continue_ok;
  logic                   timeout;
  logic                   ir_low_unused;

  // IR[14:0] carries no field this sequencer decodes
  assign ir_low_unused = ^ir[RC_LSB-1:0];

  assign opc     = ir_q[OPC_LSB +: OPC_W];
  assign timeout = (wait_cnt == CNT_LAST) && !mem_ready;

`ifdef ALU_SEQ_STEP_EN
  // Single-step: one instruction per step pulse, always back to IDLE
  assign start_ok    = run & step;
  assign continue_ok = 1'b0;
`else
  assign start_ok    = run;
  assign continue_ok = run;
`endif

  alu_opc_classify #(.OPC_W(OPC_W)) u_classify (
    .opc        (opc),
    .is_binary  (is_binary),
    .is_unary   (is_unary),
    .is_illegal (is_illegal)
  );

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = start_ok ? ST_T0 : ST_IDLE;
      ST_T0:      state_nxt = ST_T1;
      ST_T1: begin
        if (mem_ready)    state_nxt = ST_T2;
        else if (timeout) state_nxt = ST_FAULT;
        else              state_nxt = ST_T1;
      end
      ST_T2:      state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_illegal)                state_nxt = ST_ILLEGAL;
        else if (is_binary | is_unary) state_nxt = ST_T3;
        else                           state_nxt = ST_ILLEGAL;
      end
      ST_T3:      state_nxt = ST_EXEC;
      ST_EXEC:    state_nxt = ST_T5;
      ST_T5:      state_nxt = continue_ok ? ST_T0 : ST_IDLE;
      ST_ILLEGAL: state_nxt = continue_ok ? ST_T0 : ST_IDLE;
      ST_FAULT:   state_nxt = ST_FAULT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, memory wait counter, sticky fault flag and retire counter
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      mem_fault   <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_T1) ? wait_cnt + 1'b1 : '0;
      if (state == ST_T1 && timeout)
        mem_fault <= 1'b1;
      if (state == ST_T5)
        instr_count <= instr_count + 16'd1;
    end
  end

  // Instruction latch: captured once on the edge leaving T2
  always_ff @(posedge clock) begin
    if (state == ST_T2)
      ir_q <= ir[DATA_W-1:RC_LSB];
  end

  // Moore decode of every datapath and fetch strobe from the state
  always_comb begin
    alu_op     = '0;
    pc_out     = 1'b0;
    pc_in      = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    mem_read   = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    zlo_out    = 1'b0;
    mdr_out    = 1'b0;
    reg_sel    = '0;
    reg_out    = 1'b0;
    reg_in     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        zlo_out  = 1'b1;
        pc_in    = 1'b1;
        mem_read = 1'b1;
        mdr_in   = 1'b1;
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        reg_sel = ir_q[RB_LSB +: REG_W];
        reg_out = 1'b1;
        y_in    = 1'b1;
      end
      ST_EXEC: begin
        alu_op = {opc, {(DATA_W-OPC_W){1'b0}}};
        z_in   = 1'b1;
        if (is_binary) begin
          reg_sel = ir_q[RC_LSB +: REG_W];
          reg_out = 1'b1;
        end
      end
      ST_T5: begin
        zlo_out = 1'b1;
        reg_sel = ir_q[RA_LSB +: REG_W];
        reg_in  = 1'b1;
      end
      ST_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule
